regfile_read_mux: RTL
=====================

// Module: regfile_read_mux
// PURPOSE
//   Parametrised multi-port register-file read stage for the simple 32-bit processor.
//   Each port selects one of NUM_REGS register values, which are presented as a flat bus.
//   Results are registered, and the stage is decoupled by a valid/ready handshake.
//   Sits between the register bank and the ALU operand inputs, replacing the per-operand 16:1 source muxes.
// PARAMETERS
//   DATA_W    32  width of each register and each output operand
//   NUM_REGS  16  number of selectable registers (2..256, need not be a power of 2)
//   NUM_PORTS 2   number of independent read ports (source 1, source 2, ...)
//   SEL_W     4   selector width; must equal $clog2(NUM_REGS); elaboration error otherwise
// PORTS
//   clk        in   1                   system clock, rising edge
//   reset      in   1                   synchronous, active-high reset
//   regs_flat  in   NUM_REGS*DATA_W     register values; reg i at [i*DATA_W +: DATA_W]
//   req_valid  in   1                   read request present
//   req_ready  out  1                   stage can accept a request this cycle
//   req_sel    in   NUM_PORTS*SEL_W     per-port selector; port p at [p*SEL_W +: SEL_W]
//   rsp_valid  out  1                   rsp_data/rsp_err hold a valid result
//   rsp_ready  in   1                   consumer takes the result this cycle
//   rsp_data   out  NUM_PORTS*DATA_W    per-port operand, same packing as req_sel
//   rsp_err    out  NUM_PORTS           per-port flag: selector >= NUM_REGS
//   wb_en      in   1                   write-back strobe (RD_FWD_EN builds only; tie 0 otherwise)
//   wb_sel     in   SEL_W               write-back destination register
//   wb_data    in   DATA_W              write-back value
// BEHAVIOUR
//   - Reset: rsp_valid=0, rsp_data=0, rsp_err=0. A reset mid-transfer drops the held result.
//   - Handshake: req_ready = !rsp_valid || rsp_ready (combinational, one-deep pipe).
//     A request is accepted on a clock edge where req_valid && req_ready.
//   - Latency: 1 cycle. regs_flat and req_sel are sampled on the accept edge.
//     rsp_valid rises on that edge.
//   - Hold: while rsp_valid && !rsp_ready, rsp_data and rsp_err are frozen.
//     Later changes to regs_flat do not alter a held result.
//   - Drain: when rsp_ready=1 and no new request is accepted, rsp_valid falls on the next edge.
//     rsp_data keeps its last value.
//   - Back-to-back: simultaneous accept and consume gives full throughput, one result per cycle.
//   - Out of range (sel >= NUM_REGS): port data = 0 and rsp_err[p] = 1.
//     Other ports are unaffected. Never drives X or Z.
//   - Ports are fully independent; several ports may select the same register.
//   - No FSM beyond the rsp_valid bit. The output register is the only sequential state.
// CONFIGURATION
//   Macro RD_FWD_EN:
//   - Defined: on the accept edge, if wb_en && wb_sel == sel[p] && sel[p] < NUM_REGS,
//     port p captures wb_data instead of the regs_flat entry (write-then-read bypass).
//     wb_* are ignored on cycles with no accept.
//   - Undefined: wb_* ports are present but ignored; ports always read regs_flat.
// STRUCTURE
//   - Package regfile_pkg:
//     - localparams RF_DATA_W=32, RF_NUM_REGS=16, RF_SEL_W=4
//     - function sel_in_range(sel, n)
//     - typedef rf_sel_t / rf_word_t
//   - Sub-module regfile_read_port (combinational, one instance per port via generate):
//     selects the regs_flat entry, applies range check and forwarding, outputs data + err.
//   - Top: generate loop, handshake logic, output register.
// TESTING
//   1. Reset; req_valid=1, sel={p1=3,p0=0}, reg3=32'hDEAD_BEEF, reg0=32'h1.
//      Next cycle: rsp_valid=1, data={DEAD_BEEF,00000001}, err=0.
//   2. Hold rsp_ready=0 for 3 cycles, change reg3 to 32'h0.
//      rsp_data is unchanged and req_ready=0; on release the result drains once.
//   3. Stream 8 requests with rsp_ready=1 and sel=i.
//      8 consecutive results, one per cycle, in order, with no bubbles.
//   4. NUM_REGS=12, sel p0=13, p1=5.
//      rsp_data p0=0 with rsp_err=2'b01; p1 = reg5.
//   5. RD_FWD_EN build: wb_en=1, wb_sel=7, wb_data=32'hCAFE_0001, reg7=0, and accept sel=7 on both ports.
//      Both ports = CAFE_0001. Same stimulus without the macro gives 0.
//   6. Assert reset in the cycle after an accept while rsp_ready=0.
//      rsp_valid=0 and rsp_data=0 the next cycle, and req_ready=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types, default sizes and the selector range helper for the
// register-file read stage.
package regfile_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 16;
  localparam int RF_SEL_W    = 4;

  typedef logic [RF_SEL_W-1:0]  rf_sel_t;
  typedef logic [RF_DATA_W-1:0] rf_word_t;

  // True when a selector addresses an implemented register.
  function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/regfile_read_mux_if.sv
// Request/response handshake bundle of the register-file read stage.
// The master drives requests and accepts responses; the slave is the stage.
interface regfile_read_mux_if #(
  parameter int DATA_W    = 32,
  parameter int NUM_PORTS = 2,
  parameter int SEL_W     = 4
);

  logic                        req_valid;
  logic                        req_ready;
  logic [NUM_PORTS*SEL_W-1:0]  req_sel;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [NUM_PORTS*DATA_W-1:0] rsp_data;
  logic [NUM_PORTS-1:0]        rsp_err;

  modport master (
    output req_valid, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: register select, range check and, in
// RD_FWD_EN builds, write-then-read bypass from the write-back bus.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int SEL_W    = RF_SEL_W
) (
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       wb_en,
  input  logic [SEL_W-1:0]           wb_sel,
  input  logic [DATA_W-1:0]          wb_data,
  output logic [DATA_W-1:0]          data,
  output logic                       err
);

  logic in_range;

  assign in_range = sel_in_range(32'(sel), NUM_REGS);
  assign err      = !in_range;

  always_comb begin : select
    // NOTE: a default before any conditional assignment keeps this purely
    // combinational (no latch) and gives 0 for out-of-range selectors.
    data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel == SEL_W'(i)) data = regs_flat[i*DATA_W +: DATA_W];
    end
`ifdef RD_FWD_EN
    if (wb_en && in_range && (wb_sel == sel)) data = wb_data;
`endif
  end

`ifndef RD_FWD_EN
  // Write-back inputs exist for port compatibility only in this build.
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_sel, wb_data};
`endif

endmodule

// File: rtl/regfile_read_mux.sv
// Multi-port register-file read stage with a one-deep registered output
// and valid/ready decoupling. Optional bypass: define RD_FWD_EN.
module regfile_read_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W    = RF_DATA_W,
  parameter int NUM_REGS  = RF_NUM_REGS,
  parameter int NUM_PORTS = 2,
  parameter int SEL_W     = RF_SEL_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic                       wb_en,
  input  logic [SEL_W-1:0]           wb_sel,
  input  logic [DATA_W-1:0]          wb_data,
  regfile_read_mux_if.slave          bus
);

  if (SEL_W != $clog2(NUM_REGS)) begin : g_bad_sel_w
    $error("regfile_read_mux: SEL_W must equal $clog2(NUM_REGS)");
  end

  logic [NUM_PORTS*DATA_W-1:0] port_data;
  logic [NUM_PORTS-1:0]        port_err;
  logic                        accept;
  logic                        rsp_valid_q;
  logic [NUM_PORTS*DATA_W-1:0] rsp_data_q;
  logic [NUM_PORTS-1:0]        rsp_err_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    regfile_read_port #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS),
      .SEL_W   (SEL_W)
    ) u_port (
      .regs_flat(regs_flat),
      .sel      (bus.req_sel[p*SEL_W +: SEL_W]),
      .wb_en    (wb_en),
      .wb_sel   (wb_sel),
      .wb_data  (wb_data),
      .data     (port_data[p*DATA_W +: DATA_W]),
      .err      (port_err[p])
    );
  end

  // One-deep pipe: a slot frees up in the same cycle the consumer takes it.
  assign bus.req_ready = !rsp_valid_q || bus.rsp_ready;
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; the data
    // register is reset too, since a cleared output is visible behaviour.
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= port_data;
      rsp_err_q   <= port_err;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
